// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges hazard requests with the data-memory handshake.
// Optional performance counters are built only when STALL_PERF_EN is defined.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_stall,
    input  logic             hz_flush,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             err_clear,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] hz_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ERROR = 2'd2;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             mem_block;
    logic             adv_ok;
    logic [4:0]       en;

    assign mem_block = dmem_req && !dmem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            S_RUN: begin
                if (mem_block) begin
                    state_d      = S_WAIT;
                    wait_cnt_d   = CNT_W'(1);
                    flush_pend_d = flush_pend_q | hz_flush;
                end else if (!hz_stall) begin
                    flush_pend_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                    // A stall in the resume cycle keeps the pending flush for the next advance
                    if (!hz_stall) flush_pend_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d   = wait_cnt_q + CNT_W'(1);
                    flush_pend_d = flush_pend_q | hz_flush;
                end
            end
            S_ERROR: begin
                if (err_clear) begin
                    state_d      = S_RUN;
                    wait_cnt_d   = '0;
                    flush_pend_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_RUN;
                wait_cnt_d   = '0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        adv_ok      = 1'b0;
        en          = 5'b00000;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            S_RUN:   adv_ok = !mem_block;
            S_WAIT: begin
                if (dmem_ready)                    adv_ok      = 1'b1;
                else if (wait_cnt_q == WAIT_LAST)  mem_timeout = 1'b1;
            end
            default: adv_ok = 1'b0;
        endcase
        if (adv_ok) begin
            if (hz_stall) begin
                en          = 5'b00111;
                idex_bubble = 1'b1;
            end else begin
                en         = 5'b11111;
                ifid_flush = hz_flush | flush_pend_q;
            end
        end
        if (!rst_n) begin
            en          = 5'b00000;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            mem_timeout = 1'b0;
        end
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
    assign state = state_q;

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] hz_cnt_q, mem_cnt_q;
    logic             mem_frz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Counts the RUN cycle that enters MEM_WAIT as well as every frozen wait/error cycle
    assign mem_frz = (state_q == S_RUN && mem_block) ||
                     (state_q == S_WAIT && !dmem_ready) ||
                     (state_q == S_ERROR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hz_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (idex_bubble) hz_cnt_q  <= sat_inc(hz_cnt_q);
            if (mem_frz)     mem_cnt_q <= sat_inc(mem_cnt_q);
        end
    end

    assign hz_stall_cnt  = hz_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
`else
    assign hz_stall_cnt  = '0;
    assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_W=4).
// Counter expectations follow STALL_PERF_EN.
module tb_pipeline_stall_controller;

    localparam int TMO = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst_n, hz_stall, hz_flush, dmem_req, dmem_ready, err_clear;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_bubble, mem_timeout;
    logic [1:0] state;
    logic [CW-1:0] hz_stall_cnt, mem_stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hz_stall(hz_stall), .hz_flush(hz_flush),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .err_clear(err_clear),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .mem_timeout(mem_timeout), .state(state),
        .hz_stall_cnt(hz_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
    );

    typedef struct packed {
        logic [9:0]    outs;
        logic          chk;
        logic [CW-1:0] hz;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam logic [4:0] E_ALL  = 5'b11111;
    localparam logic [4:0] E_STL  = 5'b00111;
    localparam logic [4:0] E_NONE = 5'b00000;

    function automatic logic [9:0] o(input logic [4:0] en, input logic fl, input logic bb,
                                     input logic tmo, input logic [1:0] st);
        return {en, fl, bb, tmo, st};
    endfunction

    function automatic logic [CW-1:0] pc(input int v);
`ifdef STALL_PERF_EN
        return v[CW-1:0];
`else
        return (v == v) ? '0 : '1;
`endif
    endfunction

    task automatic step(input logic rs, input logic st, input logic fl, input logic rq,
                        input logic rd, input logic cl, input logic [9:0] outs,
                        input logic chk, input int hz, input int mc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rs; hz_stall = st; hz_flush = fl;
        dmem_req = rq; dmem_ready = rd; err_clear = cl;
        e.outs = outs; e.chk = chk; e.hz = pc(hz); e.mc = pc(mc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic [9:0] got;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_bubble, mem_timeout, state};
            checks++;
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s outs got=%b want=%b", nm, got, e.outs);
            end
            if (e.chk) begin
                checks++;
                if (hz_stall_cnt !== e.hz || mem_stall_cnt !== e.mc) begin
                    errors++;
                    $display("FAIL %s_cnt hz got=%0d want=%0d mem got=%0d want=%0d",
                             nm, hz_stall_cnt, e.hz, mem_stall_cnt, e.mc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; hz_stall = 1'b0; hz_flush = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; err_clear = 1'b0;
        repeat (2) @(posedge clk);
        //    rst st fl rq rd cl  expected outputs              chk hz mc  name
        step(0, 0, 0, 0, 0, 0, o(E_NONE, 0, 0, 0, 2'd0), 1, 0, 0, "reset1");
        step(0, 0, 0, 0, 0, 0, o(E_NONE, 0, 0, 0, 2'd0), 1, 0, 0, "reset2");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 0, 0, "idle");
        step(1, 1, 0, 0, 0, 0, o(E_STL,  0, 1, 0, 2'd0), 0, 0, 0, "loaduse");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 1, 0, "after_stall");
        step(1, 0, 0, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd0), 0, 0, 0, "mw_enter");
        step(1, 0, 0, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd1), 0, 0, 0, "mw_wait1");
        step(1, 0, 1, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd1), 0, 0, 0, "mw_wait2_flush");
        step(1, 0, 0, 1, 1, 0, o(E_ALL,  1, 0, 0, 2'd1), 0, 0, 0, "mw_ready_flush");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 1, 3, "mw_after");
        step(1, 1, 1, 0, 0, 0, o(E_STL,  0, 1, 0, 2'd0), 0, 0, 0, "stall_beats_flush");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 2, 3, "flush_dropped");
        step(1, 0, 0, 1, 1, 0, o(E_ALL,  0, 0, 0, 2'd0), 0, 0, 0, "same_cycle_ready");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 2, 3, "no_freeze");
        step(1, 0, 1, 0, 0, 0, o(E_ALL,  1, 0, 0, 2'd0), 0, 0, 0, "run_flush");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 0, 0, 0, "run_flush_once");
        step(1, 0, 1, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd0), 0, 0, 0, "pend_enter");
        step(1, 1, 0, 1, 1, 0, o(E_STL,  0, 1, 0, 2'd1), 0, 0, 0, "pend_stall_resume");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  1, 0, 0, 2'd0), 0, 0, 0, "pend_applied");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 3, 4, "pend_cleared");
        step(1, 0, 0, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd0), 0, 0, 0, "tmo_f1");
        step(1, 0, 1, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd1), 0, 0, 0, "tmo_f2");
        step(1, 0, 0, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd1), 0, 0, 0, "tmo_f3");
        step(1, 0, 0, 1, 0, 0, o(E_NONE, 0, 0, 1, 2'd1), 0, 0, 0, "tmo_pulse");
        step(1, 0, 0, 0, 0, 0, o(E_NONE, 0, 0, 0, 2'd2), 0, 0, 0, "err_hold1");
        step(1, 0, 0, 0, 1, 0, o(E_NONE, 0, 0, 0, 2'd2), 0, 0, 0, "err_hold2");
        step(1, 0, 0, 0, 0, 1, o(E_NONE, 0, 0, 0, 2'd2), 0, 0, 0, "err_clear");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 3, 11, "err_resume");
        for (int i = 0; i < 20; i++)
            step(1, 1, 0, 0, 0, 0, o(E_STL, 0, 1, 0, 2'd0), 0, 0, 0, "long_stall");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 15, 11, "hz_saturate");
        step(1, 0, 1, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd0), 0, 0, 0, "rst_mw_enter");
        step(0, 0, 0, 1, 0, 0, o(E_NONE, 0, 0, 0, 2'd1), 0, 0, 0, "rst_in_wait");
        step(1, 0, 0, 0, 0, 0, o(E_ALL,  0, 0, 0, 2'd0), 1, 0, 0, "rst_flush_dropped");
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
